// File: rtl/nios_core_nios2_gen2_cpu_div_cell_if.sv
// Operand/result bundle between the E/M pipeline stages and the divider cell.
// The master side is the pipeline; the slave side is the divider.
interface nios_core_nios2_gen2_cpu_div_cell_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] E_src1;
  logic [DATA_W-1:0] E_src2;
  logic              E_div_signed;
  logic              E_div_start;
  logic              E_div_abort;
  logic              M_div_busy;
  logic              M_div_done;
  logic [DATA_W-1:0] M_div_quot;
  logic [DATA_W-1:0] M_div_rem;

  modport master (
    output E_src1, E_src2, E_div_signed, E_div_start, E_div_abort,
    input  M_div_busy, M_div_done, M_div_quot, M_div_rem
  );

  modport slave (
    input  E_src1, E_src2, E_div_signed, E_div_start, E_div_abort,
    output M_div_busy, M_div_done, M_div_quot, M_div_rem
  );
endinterface

// File: rtl/nios_core_nios2_gen2_cpu_div_cell.sv
// Iterative radix-2 restoring divider (div/divu plus remainder) for the Nios II gen2 core.
// Optional macro NIOS_DIV_EARLY_OUT_EN skips the iterations when the quotient is trivially 0 or divide-by-zero.
//
// state | meaning
// IDLE  | waiting for an accepted start; operands latched on acceptance
// RUN   | one quotient bit per cycle, DATA_W cycles, down-counter to 0
// FIXUP | sign correction / divide-by-zero override, result registers loaded
// DONE  | single-cycle done pulse, then back to IDLE
module nios_core_nios2_gen2_cpu_div_cell #(
  parameter int DATA_W = 32
) (
  input  logic clk,
  input  logic reset_n,
  nios_core_nios2_gen2_cpu_div_cell_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] dvd_q;
  logic [DATA_W-1:0] dsr_q;
  logic [DATA_W-1:0] rem_q;
  logic [DATA_W-1:0] orig_dvd_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              neg_quot_q;
  logic              neg_rem_q;
  logic              div_zero_q;
  logic [DATA_W-1:0] quot_out_q;
  logic [DATA_W-1:0] rem_out_q;

  logic              load;
  logic              iter;
  logic              fix;
  logic              early;

  logic              src1_neg;
  logic              src2_neg;
  logic [DATA_W-1:0] src1_mag;
  logic [DATA_W-1:0] src2_mag;
  logic              src2_zero;

  logic [DATA_W:0]   shifted;
  logic [DATA_W:0]   trial;
  logic              quot_bit;
  logic [DATA_W-1:0] rem_nx;
  logic [DATA_W-1:0] quot_fix;
  logic [DATA_W-1:0] rem_fix;

  // Magnitudes are taken as unsigned, so |most-negative| maps onto itself and
  // the signed-overflow case falls out of the normal datapath.
  assign src1_neg  = bus.E_div_signed & bus.E_src1[DATA_W-1];
  assign src2_neg  = bus.E_div_signed & bus.E_src2[DATA_W-1];
  assign src1_mag  = src1_neg ? -bus.E_src1 : bus.E_src1;
  assign src2_mag  = src2_neg ? -bus.E_src2 : bus.E_src2;
  assign src2_zero = (bus.E_src2 == '0);

`ifdef NIOS_DIV_EARLY_OUT_EN
  assign early = src2_zero | (src1_mag < src2_mag);
`else
  assign early = 1'b0;
`endif

  // rem_q < dsr_q holds between iterations, so DATA_W+1 bits cover the trial.
  assign shifted  = {rem_q, dvd_q[DATA_W-1]};
  assign trial    = shifted - {1'b0, dsr_q};
  assign quot_bit = ~trial[DATA_W];
  assign rem_nx   = quot_bit ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];

  always_comb begin
    quot_fix = neg_quot_q ? -dvd_q : dvd_q;
    rem_fix  = neg_rem_q  ? -rem_q : rem_q;
    if (div_zero_q) begin
      quot_fix = '1;
      rem_fix  = orig_dvd_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    iter    = 1'b0;
    fix     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.E_div_start && !bus.E_div_abort) begin
          load    = 1'b1;
          state_d = early ? FIXUP : RUN;
        end
      end
      RUN: begin
        if (bus.E_div_abort) begin
          state_d = IDLE;
        end else begin
          iter = 1'b1;
          if (cnt_q == '0) begin
            state_d = FIXUP;
          end
        end
      end
      FIXUP: begin
        if (bus.E_div_abort) begin
          state_d = IDLE;
        end else begin
          fix     = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Early-out preloads quotient 0 and remainder |dividend|; the FIXUP sign
  // correction then restores the original dividend without a separate path.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dvd_q      <= '0;
      dsr_q      <= '0;
      rem_q      <= '0;
      orig_dvd_q <= '0;
      cnt_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
    end else if (load) begin
      dvd_q      <= early ? '0 : src1_mag;
      rem_q      <= early ? src1_mag : '0;
      dsr_q      <= src2_mag;
      orig_dvd_q <= bus.E_src1;
      cnt_q      <= CNT_W'(DATA_W - 1);
      neg_quot_q <= src1_neg ^ src2_neg;
      neg_rem_q  <= src1_neg;
      div_zero_q <= src2_zero;
    end else if (iter) begin
      dvd_q <= {dvd_q[DATA_W-2:0], quot_bit};
      rem_q <= rem_nx;
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      quot_out_q <= '0;
      rem_out_q  <= '0;
    end else if (fix) begin
      quot_out_q <= quot_fix;
      rem_out_q  <= rem_fix;
    end
  end

  assign bus.M_div_busy = (state_q == RUN) || (state_q == FIXUP);
  assign bus.M_div_done = (state_q == DONE);
  assign bus.M_div_quot = quot_out_q;
  assign bus.M_div_rem  = rem_out_q;

endmodule
